int_ram_loader: RTL and testbench

//  Ping-pong write/read controller sitting directly upstream of the two-frame intrinsic RAM.
//  - Accepts channel LLRs as a valid/ready stream, saturates them to DATA_WIDTH and writes
//    one frame into the free buffer.
//  - Hands full frames to the decoder and routes decoder reads to the buffer being decoded.
//  - While the decoder reads one frame, the next frame loads into the other buffer.

---
 rtl/ldpc_int_pkg.sv | 33 +++
 rtl/int_buf_ctrl.sv | 47 ++++
 rtl/int_ram_loader.sv | 170 +++++++++++++++++
 tb/tb_int_ram_loader.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_int_pkg.sv
// Shared types and helpers for the intrinsic-LLR ping-pong buffer path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package ldpc_int_pkg;

    // Life cycle of one intrinsic RAM buffer.
    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_FILLING,
        BUF_FULL,
        BUF_DECODING
    } int_buf_state_t;

    // Largest stored LLR magnitude. The range is symmetric, so the most-negative
    // two's complement code is never produced.
    function automatic int llr_max(input int data_width);
        return (1 << (data_width - 1)) - 1;
    endfunction

    // Clip a sign-extended channel LLR into [-llr_max, +llr_max].
    function automatic int sat_llr(input int llr, input int data_width);
        int lim;
        lim = llr_max(data_width);
        if (llr > lim) begin
            return lim;
        end
        if (llr < -lim) begin
            return -lim;
        end
        return llr;
    endfunction

endpackage

// File: rtl/int_buf_ctrl.sv
// State tracker for one intrinsic RAM buffer: EMPTY -> FILLING -> FULL -> DECODING -> EMPTY.
// Latency: state updates on the clock edge that sees the qualifying strobe.
// Backpressure: none; the parent only presents strobes that are legal in the current state.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (reset state EMPTY)
//   fill_start  a word is being written into this buffer (only acted on when EMPTY)
//   fill_end    the last word of the frame is being written (only acted on when FILLING)
//   ack         decoder takes this buffer (only acted on when FULL)
//   done        decoder finished this buffer (only acted on when DECODING)
//   state       current buffer state
module int_buf_ctrl
    import ldpc_int_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           fill_start,
    input  logic           fill_end,
    input  logic           ack,
    input  logic           done,
    output int_buf_state_t state
);

    int_buf_state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // A frame is at least two words long, so fill_start and fill_end never
    // need to be honoured in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            BUF_EMPTY:    if (fill_start) state_nxt = BUF_FILLING;
            BUF_FILLING:  if (fill_end)   state_nxt = BUF_FULL;
            BUF_FULL:     if (ack)        state_nxt = BUF_DECODING;
            BUF_DECODING: if (done)       state_nxt = BUF_EMPTY;
            default:                      state_nxt = BUF_EMPTY;
        endcase
    end

endmodule

// File: rtl/int_ram_loader.sv
// Ping-pong loader for the two-frame intrinsic RAM: saturates channel LLRs into the free
// buffer and routes decoder reads to the buffer being decoded.
// Latency: RAM write strobes in the accept cycle; dec_rd_data one cycle after dec_rd_en.
// Backpressure: llr_ready drops while the target buffer is FULL or DECODING; nothing is lost.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   llr_valid/data/ready    channel LLR stream (valid/ready)
//   frame_valid, frame_ack  frame handoff to the decoder (valid & ack)
//   dec_done                decoder finished its frame (1-cycle pulse)
//   dec_rd_en, dec_addr     decoder read request
//   dec_rd_data             decoder read data (held between reads)
//   dec_buf                 buffer being decoded (0 -> frame 1, 1 -> frame 2)
//   ram_*[2:1]              per-buffer RAM port controls; index 1 is frame 1
module int_ram_loader
    import ldpc_int_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IN_WIDTH   = 10,
    parameter int ADDR_WIDTH = 8,
    parameter int FRAME_LEN  = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           llr_valid,
    input  logic [IN_WIDTH-1:0]            llr_data,
    output logic                           llr_ready,
    output logic                           frame_valid,
    input  logic                           frame_ack,
    input  logic                           dec_done,
    input  logic                           dec_rd_en,
    input  logic [ADDR_WIDTH-1:0]          dec_addr,
    output logic [DATA_WIDTH-1:0]          dec_rd_data,
    output logic                           dec_buf,
    output logic [2:1][DATA_WIDTH-1:0]     ram_data_in,
    output logic [2:1][ADDR_WIDTH-1:0]     ram_address,
    output logic [2:1]                     ram_chip_sel,
    output logic [2:1]                     ram_write_en,
    input  logic [2:1][DATA_WIDTH-1:0]     ram_data_out
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(FRAME_LEN - 1);

    int_buf_state_t            buf_state [2];
    logic                      wr_buf;
    logic [ADDR_WIDTH-1:0]     wr_ptr;
    logic                      oldest;      // next buffer to hand to the decoder
    logic                      rd_pend;
    logic                      rd_buf_q;
    logic [DATA_WIDTH-1:0]     rd_hold;

    logic                      any_dec;
    logic                      wr_fire;
    logic                      wr_last;
    logic                      rd_fire;
    logic                      ack_fire;
    logic signed [31:0]        llr_ext;
    logic [DATA_WIDTH-1:0]     sat_dat;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign any_dec     = (buf_state[0] == BUF_DECODING) || (buf_state[1] == BUF_DECODING);
    assign llr_ready   = (buf_state[wr_buf] == BUF_EMPTY) || (buf_state[wr_buf] == BUF_FILLING);
    // Buffers fill alternately, so handing off in load order reduces to toggling 'oldest'.
    assign frame_valid = !any_dec && (buf_state[oldest] == BUF_FULL);
    assign ack_fire    = frame_valid && frame_ack;
    // rst_n keeps the RAM strobes quiet while reset is held, even with a live stream.
    assign wr_fire     = llr_valid && llr_ready && rst_n;
    assign wr_last     = wr_fire && (wr_ptr == LAST_PTR);
    // dec_buf only names a live buffer while one is DECODING.
    assign rd_fire     = dec_rd_en && any_dec && rst_n;

    // ------------------------------------------------------------------
    // Saturation
    // ------------------------------------------------------------------
    always_comb begin
        llr_ext = {{(32 - IN_WIDTH){llr_data[IN_WIDTH-1]}}, llr_data};
        sat_dat = DATA_WIDTH'(sat_llr(llr_ext, DATA_WIDTH));
    end

    // ------------------------------------------------------------------
    // Per-buffer state machines
    // ------------------------------------------------------------------
    int_buf_ctrl u_buf0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_start (wr_fire && !wr_buf),
        .fill_end   (wr_last && !wr_buf),
        .ack        (ack_fire && !oldest),
        .done       (dec_done && !dec_buf),
        .state      (buf_state[0])
    );

    int_buf_ctrl u_buf1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_start (wr_fire && wr_buf),
        .fill_end   (wr_last && wr_buf),
        .ack        (ack_fire && oldest),
        .done       (dec_done && dec_buf),
        .state      (buf_state[1])
    );

    // ------------------------------------------------------------------
    // Write pointer, buffer selection, handoff order
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            wr_buf  <= 1'b0;
            oldest  <= 1'b0;
            dec_buf <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_last) begin
                    wr_ptr <= '0;
                    wr_buf <= ~wr_buf;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (ack_fire) begin
                dec_buf <= oldest;
                oldest  <= ~oldest;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return: the RAM answers one cycle after the request; between
    // reads the last returned word is held.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend  <= 1'b0;
            rd_buf_q <= 1'b0;
            rd_hold  <= '0;
        end else begin
            rd_pend  <= rd_fire;
            rd_buf_q <= dec_buf;
            rd_hold  <= dec_rd_data;
        end
    end

    assign dec_rd_data = rd_pend ? (rd_buf_q ? ram_data_out[2] : ram_data_out[1]) : rd_hold;

    // ------------------------------------------------------------------
    // RAM port muxing. The write buffer is never the decoded buffer, so the
    // write and read arms never select the same port in one cycle.
    // ------------------------------------------------------------------
    always_comb begin
        ram_chip_sel = '0;
        ram_write_en = '0;
        ram_address  = '0;
        ram_data_in  = '0;
        for (int b = 0; b < 2; b++) begin
            if (wr_fire && (wr_buf == 1'(b))) begin
                ram_chip_sel[b+1] = 1'b1;
                ram_write_en[b+1] = 1'b1;
                ram_address[b+1]  = wr_ptr;
                ram_data_in[b+1]  = sat_dat;
            end else if (rd_fire && (dec_buf == 1'(b))) begin
                ram_chip_sel[b+1] = 1'b1;
                ram_address[b+1]  = dec_addr;
            end
        end
    end

endmodule

// File: tb/tb_int_ram_loader.sv
module tb_int_ram_loader;

    localparam int DW = 8;
    localparam int IW = 10;
    localparam int AW = 8;
    localparam int FL = 256;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 llr_valid;
    logic [IW-1:0]        llr_data;
    logic                 llr_ready;
    logic                 frame_valid;
    logic                 frame_ack;
    logic                 dec_done;
    logic                 dec_rd_en;
    logic [AW-1:0]        dec_addr;
    logic [DW-1:0]        dec_rd_data;
    logic                 dec_buf;
    logic [2:1][DW-1:0]   ram_data_in;
    logic [2:1][AW-1:0]   ram_address;
    logic [2:1]           ram_chip_sel;
    logic [2:1]           ram_write_en;
    logic [2:1][DW-1:0]   ram_data_out;

    always #5 clk = ~clk;

    int_ram_loader #(
        .DATA_WIDTH(DW), .IN_WIDTH(IW), .ADDR_WIDTH(AW), .FRAME_LEN(FL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .llr_valid(llr_valid), .llr_data(llr_data), .llr_ready(llr_ready),
        .frame_valid(frame_valid), .frame_ack(frame_ack), .dec_done(dec_done),
        .dec_rd_en(dec_rd_en), .dec_addr(dec_addr), .dec_rd_data(dec_rd_data),
        .dec_buf(dec_buf),
        .ram_data_in(ram_data_in), .ram_address(ram_address),
        .ram_chip_sel(ram_chip_sel), .ram_write_en(ram_write_en),
        .ram_data_out(ram_data_out)
    );

    // Two-frame synchronous RAM behind the loader.
    logic [DW-1:0] ram_mem [2][FL];
    always @(posedge clk) begin
        for (int f = 1; f <= 2; f++) begin
            if (ram_chip_sel[f]) begin
                if (ram_write_en[f]) ram_mem[f-1][ram_address[f]] <= ram_data_in[f];
                else                 ram_data_out[f] <= ram_mem[f-1][ram_address[f]];
            end
        end
    end

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------
    // Reference model: frames load alternately into buffers 0/1, complete
    // frames queue up in load order, at most one frame is being decoded.
    // ------------------------------------------------------------------
    int            loaded;      // frames completed since reset
    int            wcnt;        // words into the frame being loaded
    int            dec_idx;     // buffer being decoded, -1 if none
    int            full_q[$];   // completed frames waiting for the decoder
    logic [DW-1:0] exp_mem [2][FL];
    bit            rd_exp_pend;
    logic [DW-1:0] rd_exp_val;
    bit            mon_en = 1'b0;

    function automatic int to_int(input logic [IW-1:0] d);
        return int'($signed(d));
    endfunction

    function automatic int sat_ref(input int v);
        int lim;
        lim = (1 << (DW - 1)) - 1;
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic bit in_full(input int b);
        foreach (full_q[i]) if (full_q[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        loaded = 0; wcnt = 0; dec_idx = -1; full_q.delete(); rd_exp_pend = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            int tf;
            int old_dec;
            bit exp_rdy, exp_fv, acc;
            logic [2:1] exp_cs, exp_we;
            logic [DW-1:0] exp_d;
            tf      = loaded % 2;
            exp_rdy = !in_full(tf) && (dec_idx != tf);
            exp_fv  = (full_q.size() > 0) && (dec_idx < 0);
            exp_d   = DW'(sat_ref(to_int(llr_data)));
            total++;
            if (llr_ready !== exp_rdy) begin
                bad++; $display("FAIL mon_ready got=%b want=%b t=%0t", llr_ready, exp_rdy, $time);
            end
            total++;
            if (frame_valid !== exp_fv) begin
                bad++; $display("FAIL mon_frame_valid got=%b want=%b t=%0t", frame_valid, exp_fv, $time);
            end
            acc = llr_valid && exp_rdy;
            exp_cs = '0; exp_we = '0;
            if (acc) begin
                exp_cs[tf+1] = 1'b1; exp_we[tf+1] = 1'b1;
                total++;
                if (ram_address[tf+1] !== AW'(wcnt) || ram_data_in[tf+1] !== exp_d) begin
                    bad++; $display("FAIL mon_write frame=%0d got addr=%0d data=%0d want addr=%0d data=%0d t=%0t",
                                    tf + 1, ram_address[tf+1], ram_data_in[tf+1], wcnt, exp_d, $time);
                end
            end
            if (dec_rd_en && dec_idx >= 0) begin
                exp_cs[dec_idx+1] = 1'b1;
                total++;
                if (ram_address[dec_idx+1] !== dec_addr) begin
                    bad++; $display("FAIL mon_read_addr got=%0d want=%0d t=%0t", ram_address[dec_idx+1], dec_addr, $time);
                end
            end
            total++;
            if (ram_chip_sel !== exp_cs || ram_write_en !== exp_we) begin
                bad++; $display("FAIL mon_strobes got cs=%b we=%b want cs=%b we=%b t=%0t",
                                ram_chip_sel, ram_write_en, exp_cs, exp_we, $time);
            end
            if (rd_exp_pend) begin
                total++;
                if (dec_rd_data !== rd_exp_val) begin
                    bad++; $display("FAIL mon_rd_data got=%0d want=%0d t=%0t", dec_rd_data, rd_exp_val, $time);
                end
            end
            if (dec_idx >= 0) begin
                total++;
                if (dec_buf !== dec_idx[0]) begin
                    bad++; $display("FAIL mon_dec_buf got=%b want=%0d t=%0t", dec_buf, dec_idx, $time);
                end
            end
            // advance the model across the coming clock edge
            rd_exp_pend = dec_rd_en && (dec_idx >= 0);
            if (rd_exp_pend) rd_exp_val = exp_mem[dec_idx][dec_addr];
            if (acc) begin
                exp_mem[tf][wcnt] = exp_d;
                wcnt++;
                if (wcnt == FL) begin
                    wcnt = 0; full_q.push_back(tf); loaded++;
                end
            end
            old_dec = dec_idx;
            if (dec_done && old_dec >= 0) dec_idx = -1;
            if (frame_ack && exp_fv) dec_idx = full_q.pop_front();
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (drive at posedge+1)
    // ------------------------------------------------------------------
    task automatic apply_reset();
        rst_n = 1'b0;
        llr_valid = 1'b0; llr_data = '0; frame_ack = 1'b0; dec_done = 1'b0;
        dec_rd_en = 1'b0; dec_addr = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    // Present one LLR and wait (bounded) until it is accepted on the coming edge.
    task automatic push(input logic [IW-1:0] d);
        int n;
        n = 0;
        @(posedge clk); #1;
        llr_valid = 1'b1; llr_data = d;
        @(negedge clk);
        while (!llr_ready && n < 100) begin
            @(negedge clk); n++;
        end
        total++;
        if (!llr_ready) begin
            bad++; $display("FAIL push_timeout ready=%b want=1", llr_ready);
        end
    endtask

    task automatic push_random(input int count);
        for (int i = 0; i < count; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1 llr_valid = 1'b0;
            end
            push(IW'($urandom_range(0, (1 << IW) - 1)));
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        llr_valid = 1'b0; llr_data = '0; frame_ack = 1'b0; dec_done = 1'b0;
        dec_rd_en = 1'b0; dec_addr = '0;
        @(negedge clk);
        total++;
        if (llr_ready !== 1'b1 || frame_valid !== 1'b0 || dec_rd_data !== '0 || dec_buf !== 1'b0) begin
            bad++; $display("FAIL reset_outputs ready=%b fv=%b rd=%0d buf=%b want 1 0 0 0",
                            llr_ready, frame_valid, dec_rd_data, dec_buf);
        end
        total++;
        if (ram_chip_sel !== '0 || ram_write_en !== '0 || ram_address !== '0 || ram_data_in !== '0) begin
            bad++; $display("FAIL reset_ram cs=%b we=%b addr=%h din=%h want all zero",
                            ram_chip_sel, ram_write_en, ram_address, ram_data_in);
        end
        apply_reset();
        @(negedge clk);
        total++;
        if (llr_ready !== 1'b1 || frame_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release ready=%b fv=%b want 1 0", llr_ready, frame_valid);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < FL; i++) push(IW'(i));
        // next frame's first word right behind the last one
        push(IW'($urandom_range(0, 1023)));
        total++;
        if (frame_valid !== 1'b1 || llr_ready !== 1'b1) begin
            bad++; $display("FAIL stream_handoff fv=%b ready=%b want 1 1", frame_valid, llr_ready);
        end
        total++;
        if (ram_write_en !== 2'b10 || ram_address[2] !== '0) begin
            bad++; $display("FAIL stream_frame2_start we=%b addr=%0d want we=10 addr=0", ram_write_en, ram_address[2]);
        end
    endtask

    task automatic test_saturation();
        logic [IW-1:0] vin  [4];
        logic [DW-1:0] vexp [4];
        vin[0] = IW'(300);  vexp[0] = DW'(127);
        vin[1] = IW'(-300); vexp[1] = DW'(-127);
        vin[2] = IW'(-128); vexp[2] = DW'(-127);
        vin[3] = IW'(5);    vexp[3] = DW'(5);
        for (int i = 0; i < 4; i++) begin
            push(vin[i]);
            total++;
            if (ram_write_en[2] !== 1'b1 || ram_data_in[2] !== vexp[i]) begin
                bad++; $display("FAIL saturation_%0d we=%b data=%0d want we=1 data=%0d",
                                i, ram_write_en[2], $signed(ram_data_in[2]), $signed(vexp[i]));
            end
        end
    endtask

    task automatic test_stall();
        push_random(FL - 5);
        @(posedge clk); #1;
        llr_valid = 1'b1; llr_data = IW'($urandom_range(0, 1023));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (llr_ready !== 1'b0 || ram_write_en !== '0) begin
                bad++; $display("FAIL stall_cycle_%0d ready=%b we=%b want 0 00", i, llr_ready, ram_write_en);
            end
            @(posedge clk); #1;
        end
        frame_ack = 1'b1;
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b1) begin
            bad++; $display("FAIL stall_frame_valid got=%b want=1", frame_valid);
        end
        @(posedge clk); #1 frame_ack = 1'b0; dec_done = 1'b1;
        @(posedge clk); #1 dec_done = 1'b0;
        @(negedge clk);
        total++;
        if (llr_ready !== 1'b1 || ram_write_en !== 2'b01 || ram_address[1] !== '0) begin
            bad++; $display("FAIL stall_resume ready=%b we=%b addr=%0d want 1 01 0", llr_ready, ram_write_en, ram_address[1]);
        end
        @(posedge clk); #1 llr_valid = 1'b0;
    endtask

    task automatic test_read();
        logic [DW-1:0] want;
        int cyc;
        apply_reset();
        // stray ack/done with nothing to act on
        @(posedge clk); #1 frame_ack = 1'b1; dec_done = 1'b1;
        @(posedge clk); #1 frame_ack = 1'b0; dec_done = 1'b0;
        push_random(FL);
        @(posedge clk); #1 llr_valid = 1'b0; frame_ack = 1'b1;
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b1) begin
            bad++; $display("FAIL read_frame_valid got=%b want=1", frame_valid);
        end
        @(posedge clk); #1 frame_ack = 1'b0; dec_rd_en = 1'b1; dec_addr = AW'(7);
        @(posedge clk); #1 dec_rd_en = 1'b0;
        want = exp_mem[0][7];
        @(negedge clk);
        total++;
        if (dec_rd_data !== want) begin
            bad++; $display("FAIL read_addr7 got=%0d want=%0d", dec_rd_data, want);
        end
        @(negedge clk);
        total++;
        if (dec_rd_data !== want) begin
            bad++; $display("FAIL read_hold got=%0d want=%0d", dec_rd_data, want);
        end
        // concurrent loading of frame 2 with random reads of frame 1
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk); #1;
            llr_valid = 1'b0; dec_rd_en = 1'b0;
            if (wcnt == FL - 1) break;
            llr_valid = ($urandom_range(0, 3) != 0);
            llr_data  = IW'($urandom_range(0, 1023));
            dec_rd_en = ($urandom_range(0, 1) != 0);
            dec_addr  = AW'($urandom_range(0, FL - 1));
            cyc++;
        end
        total++;
        if (wcnt != FL - 1) begin
            bad++; $display("FAIL read_load_timeout words=%0d want=%0d", wcnt, FL - 1);
        end
    endtask

    task automatic test_done_collision();
        llr_valid = 1'b1; llr_data = IW'($urandom_range(0, 1023)); dec_done = 1'b1;
        @(negedge clk);
        total++;
        if (ram_write_en !== 2'b10 || ram_address[2] !== AW'(FL - 1) || frame_valid !== 1'b0) begin
            bad++; $display("FAIL collision_last_write we=%b addr=%0d fv=%b want 10 %0d 0",
                            ram_write_en, ram_address[2], frame_valid, FL - 1);
        end
        @(posedge clk); #1 llr_valid = 1'b0; dec_done = 1'b0;
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b1 || llr_ready !== 1'b1) begin
            bad++; $display("FAIL collision_next fv=%b ready=%b want 1 1", frame_valid, llr_ready);
        end
        @(posedge clk); #1 frame_ack = 1'b1;
        @(posedge clk); #1 frame_ack = 1'b0; dec_rd_en = 1'b1; dec_addr = AW'(3);
        @(negedge clk);
        total++;
        if (dec_buf !== 1'b1) begin
            bad++; $display("FAIL collision_dec_buf got=%b want=1", dec_buf);
        end
        @(posedge clk); #1 dec_rd_en = 1'b0;
        @(negedge clk);
        total++;
        if (dec_rd_data !== exp_mem[1][3]) begin
            bad++; $display("FAIL collision_read got=%0d want=%0d", dec_rd_data, exp_mem[1][3]);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        push_random(100);
        @(posedge clk); #1;
        llr_valid = 1'b1; llr_data = IW'($urandom_range(0, 1023));
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        model_clear();
        #1;
        total++;
        if (llr_ready !== 1'b1 || frame_valid !== 1'b0 || dec_rd_data !== '0 || dec_buf !== 1'b0) begin
            bad++; $display("FAIL async_reset_outputs ready=%b fv=%b rd=%0d buf=%b want 1 0 0 0",
                            llr_ready, frame_valid, dec_rd_data, dec_buf);
        end
        total++;
        if (ram_chip_sel !== '0 || ram_write_en !== '0 || ram_address !== '0 || ram_data_in !== '0) begin
            bad++; $display("FAIL async_reset_ram cs=%b we=%b addr=%h din=%h want all zero",
                            ram_chip_sel, ram_write_en, ram_address, ram_data_in);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; mon_en = 1'b1;
        llr_data = IW'($urandom_range(0, 1023));
        @(negedge clk);
        total++;
        if (ram_write_en !== 2'b01 || ram_address[1] !== '0) begin
            bad++; $display("FAIL async_reset_restart we=%b addr=%0d want 01 0", ram_write_en, ram_address[1]);
        end
        @(posedge clk); #1 llr_valid = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        model_clear();
        test_reset();
        test_stream();
        test_saturation();
        test_stall();
        test_read();
        test_done_collision();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
